// File: rtl/i2s_sample_output.sv
// I2S output stage: buffers 16-bit mono samples in a small FIFO and serialises each one
// onto both stereo channels of an I2S frame, with BCLK/LRCLK derived from i_Clock.
module i2s_sample_output #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BCLK_DIV   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_SampleReady,
    input  logic [15:0]                   i_Sample,
    input  logic                          i_ClearFlags,
    output logic                          o_I2S_BCLK,
    output logic                          o_I2S_LRCLK,
    output logic                          o_I2S_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
    output logic                          o_Overflow,
    output logic                          o_Underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = $clog2(BCLK_DIV);

    localparam logic [DW-1:0] DivLast = DW'(BCLK_DIV - 1);
    localparam logic [LW-1:0] LvlFull = LW'(FIFO_DEPTH);
    localparam logic [4:0]    SlotLast = 5'd31;

    // Bit-clock divider
    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic          bclk_fall;

    // Frame serialiser
    logic [4:0]    slot_q, slot_d;
    logic          lrclk_q, lrclk_d;
    logic          data_q, data_d;
    logic [31:0]   shift_q, shift_d;
    logic          frame_start;

    // Sample FIFO
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic          underrun;

    // Sticky flags
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    always_comb begin
        div_d     = div_q + 1'b1;
        bclk_d    = bclk_q;
        bclk_fall = 1'b0;
        if (div_q == DivLast) begin
            div_d     = '0;
            bclk_d    = ~bclk_q;
            bclk_fall = bclk_q;
        end
    end

    assign frame_start = bclk_fall && (slot_q == SlotLast);
    assign fifo_full   = (level_q == LvlFull);
    assign fifo_empty  = (level_q == '0);
    assign rd_data     = mem_q[rd_ptr_q];

    // No bypass: a push landing on the frame-start edge is only visible to the next frame.
    assign pop      = frame_start && !fifo_empty;
    assign underrun = frame_start && fifo_empty;
    assign push     = i_SampleReady && (!fifo_full || pop);
    assign drop     = i_SampleReady && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // DATA always takes bit 31 of the shift register. After 31 shifts the previous
    // frame's LSB sits in bit 31, which yields the one-bit I2S delay at slot 0.
    always_comb begin
        slot_d  = slot_q;
        lrclk_d = lrclk_q;
        data_d  = data_q;
        shift_d = shift_q;
        if (bclk_fall) begin
            slot_d  = slot_q + 5'd1;
            lrclk_d = slot_d[4];
            data_d  = shift_q[31];
            if (frame_start) begin
                shift_d = pop ? {rd_data, rd_data} : 32'd0;
            end else begin
                shift_d = {shift_q[30:0], 1'b0};
            end
        end
    end

    // A set event in the same cycle as a clear wins.
    always_comb begin
        ovf_d = drop     | (ovf_q & ~i_ClearFlags);
        unf_d = underrun | (unf_q & ~i_ClearFlags);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            div_q    <= '0;
            bclk_q   <= 1'b0;
            slot_q   <= SlotLast;
            lrclk_q  <= 1'b0;
            data_q   <= 1'b0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            slot_q   <= slot_d;
            lrclk_q  <= lrclk_d;
            data_q   <= data_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage needs no reset; the pointers and level define what is valid.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_Sample;
        end
    end

    assign o_I2S_BCLK  = bclk_q;
    assign o_I2S_LRCLK = lrclk_q;
    assign o_I2S_DATA  = data_q;
    assign o_FifoLevel = level_q;
    assign o_Overflow  = ovf_q;
    assign o_Underflow = unf_q;

endmodule

// File: tb/tb_i2s_sample_output.sv
// Directed + randomized bench for i2s_sample_output, checked every cycle against a
// frame-level reference model built from cycle-count arithmetic and a sample queue.
module tb_i2s_sample_output;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned BDIV  = 4;
    localparam int unsigned FRAME = 64 * BDIV;

    logic        clk;
    logic        i_Reset;
    logic        i_SampleReady;
    logic [15:0] i_Sample;
    logic        i_ClearFlags;
    logic        o_I2S_BCLK;
    logic        o_I2S_LRCLK;
    logic        o_I2S_DATA;
    logic [3:0]  o_FifoLevel;
    logic        o_Overflow;
    logic        o_Underflow;

    i2s_sample_output #(
        .FIFO_DEPTH (DEPTH),
        .BCLK_DIV   (BDIV)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (i_Reset),
        .i_SampleReady (i_SampleReady),
        .i_Sample      (i_Sample),
        .i_ClearFlags  (i_ClearFlags),
        .o_I2S_BCLK    (o_I2S_BCLK),
        .o_I2S_LRCLK   (o_I2S_LRCLK),
        .o_I2S_DATA    (o_I2S_DATA),
        .o_FifoLevel   (o_FifoLevel),
        .o_Overflow    (o_Overflow),
        .o_Underflow   (o_Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state: n counts rising edges since reset release.
    int          n;
    int          m_slot;
    logic [15:0] m_fifo[$];
    logic [31:0] m_w;
    logic        m_ovf, m_unf, m_bclk, m_lr, m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_edge(input logic rst, input logic rdy, input logic [15:0] smp,
                              input logic clr);
        logic empty_pop;
        logic dropped;
        if (rst) begin
            n = 0; m_slot = 31; m_fifo.delete(); m_w = '0;
            m_ovf = 0; m_unf = 0; m_bclk = 0; m_lr = 0; m_data = 0;
            return;
        end
        empty_pop = 0;
        dropped   = 0;
        n++;
        m_bclk = ((n / BDIV) % 2) == 1;
        if (n % (2 * BDIV) == 0) begin
            m_slot = (m_slot + 1) % 32;
            m_lr   = (m_slot >= 16);
            if (m_slot == 0) begin
                m_data = m_w[0];
                if (m_fifo.size() > 0) begin
                    m_w = {m_fifo[0], m_fifo[0]};
                    void'(m_fifo.pop_front());
                end else begin
                    m_w = '0;
                    empty_pop = 1;
                end
            end else begin
                m_data = m_w[32 - m_slot];
            end
        end
        if (rdy) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(smp);
            else dropped = 1;
        end
        m_ovf = dropped   ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = empty_pop ? 1'b1 : (clr ? 1'b0 : m_unf);
    endtask

    task automatic tick(input logic rdy, input logic [15:0] smp, input logic clr);
        i_SampleReady = rdy;
        i_Sample      = smp;
        i_ClearFlags  = clr;
        @(posedge clk);
        model_edge(i_Reset, rdy, smp, clr);
        #1;
        chk("bclk",  32'(o_I2S_BCLK),  32'(m_bclk));
        chk("lrclk", 32'(o_I2S_LRCLK), 32'(m_lr));
        chk("data",  32'(o_I2S_DATA),  32'(m_data));
        chk("level", 32'(o_FifoLevel), 32'(m_fifo.size()));
        chk("ovf",   32'(o_Overflow),  32'(m_ovf));
        chk("unf",   32'(o_Underflow), 32'(m_unf));
        i_SampleReady = 1'b0;
        i_ClearFlags  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 16'h0, 1'b0);
    endtask

    task automatic apply_reset(input int cycles);
        i_Reset = 1'b1;
        idle(cycles);
        i_Reset = 1'b0;
    endtask

    logic [31:0] bits;

    initial begin
        i_Reset = 1'b1; i_SampleReady = 1'b0; i_Sample = '0; i_ClearFlags = 1'b0;
        n = 0; m_slot = 31; m_w = '0;
        m_ovf = 0; m_unf = 0; m_bclk = 0; m_lr = 0; m_data = 0;

        // Idle for 10 frames: clocks run, zero data, underflow from first slot 0
        apply_reset(2);
        chk("rst_level", 32'(o_FifoLevel), 32'd0);
        idle(10 * FRAME);
        chk("idle_unf",   32'(o_Underflow), 32'd1);
        chk("idle_level", 32'(o_FifoLevel), 32'd0);
        tick(1'b0, 16'h0, 1'b1);
        chk("idle_clear_unf", 32'(o_Underflow), 32'd0);
        chk("idle_clear_ovf", 32'(o_Overflow),  32'd0);

        // Single known sample before the first slot 0
        apply_reset(1);
        tick(1'b1, 16'hA5C3, 1'b0);
        while (n < 3 * BDIV) idle(1);
        chk("a5c3_no_unf", 32'(o_Underflow), 32'd0);
        bits = '0;
        for (int b = 0; b < 32; b++) begin
            idle(2 * BDIV);
            bits = {bits[30:0], o_I2S_DATA};
        end
        chk("a5c3_frame", bits, 32'hA5C3A5C3);

        // Nine back-to-back pushes into depth 8; the 9th drop coincides with a clear
        apply_reset(1);
        while (n < 2 * BDIV) idle(1);
        for (int i = 0; i < 8; i++) tick(1'b1, 16'($urandom), 1'b0);
        tick(1'b1, 16'($urandom), 1'b1);
        chk("ovf_beats_clear", 32'(o_Overflow),  32'd1);
        chk("full_level",      32'(o_FifoLevel), 32'd8);
        idle(9 * FRAME);
        chk("drained_level", 32'(o_FifoLevel), 32'd0);

        // Push coincident with the slot-0 pop on an empty FIFO
        tick(1'b0, 16'h0, 1'b1);
        while (((n + 1) % FRAME) != 2 * BDIV) idle(1);
        tick(1'b1, 16'($urandom), 1'b0);
        chk("coinc_unf",   32'(o_Underflow), 32'd1);
        chk("coinc_level", 32'(o_FifoLevel), 32'd1);
        idle(2 * FRAME);
        chk("coinc_drained", 32'(o_FifoLevel), 32'd0);

        // Reset at slot 9 with three entries queued
        for (int i = 0; i < 3; i++) tick(1'b1, 16'($urandom), 1'b0);
        while ((n % FRAME) != 2 * BDIV * 10) idle(1);
        chk("pre_rst_level", 32'(o_FifoLevel), 32'd3);
        apply_reset(1);
        chk("mid_rst_level", 32'(o_FifoLevel), 32'd0);
        chk("mid_rst_bclk",  32'(o_I2S_BCLK),  32'd0);
        chk("mid_rst_unf",   32'(o_Underflow), 32'd0);
        idle(2 * BDIV);
        chk("post_rst_unf",  32'(o_Underflow), 32'd1);
        chk("post_rst_data", 32'(o_I2S_DATA),  32'd0);
        idle(FRAME);

        // Randomized traffic around the rate-matched point
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 199) == 0), 16'($urandom),
                 ($urandom_range(0, 499) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
